// File: rtl/ns_1hot2bin_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ns_1hot2bin_pipe
// Description : Registered one-hot to binary encoder with valid/ready on both
//               sides, a 2-entry output buffer and a saturating counter of
//               illegal codes. Define NS_1HOT2BIN_PRIORITY_EN to encode
//               multi-hot inputs as their lowest set bit.
// Revision    : 1.0 - initial release
// ============================================================================
module ns_1hot2bin_pipe #(
  parameter int ONE_HOT_WIDTH = 8,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [ONE_HOT_WIDTH-1:0]         one_hot_code,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [$clog2(ONE_HOT_WIDTH)-1:0] bin_code,
  output logic                             out_err,
  output logic [ERR_CNT_WIDTH-1:0]         err_cnt,
  input  logic                             err_cnt_clr
);

  localparam int BIN_WIDTH = $clog2(ONE_HOT_WIDTH);
  localparam int ENTRY_W   = BIN_WIDTH + 1;
  localparam logic [ONE_HOT_WIDTH-1:0] c_one = ONE_HOT_WIDTH'(1);

  logic [BIN_WIDTH-1:0] low_idx;
  logic [BIN_WIDTH-1:0] enc_bin;
  logic                 enc_err;
  logic                 is_zero;
`ifndef NS_1HOT2BIN_PRIORITY_EN
  logic                 is_single;
`endif

  // Entries are {bin, err}; head_q always drives the outputs.
  logic [ENTRY_W-1:0]       head_q, head_d;
  logic [ENTRY_W-1:0]       tail_q, tail_d;
  logic [1:0]               count_q, count_d;
  logic                     in_ready_q, in_ready_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic                     push;
  logic                     pop;

  always_comb begin
    low_idx = '0;
    for (int i = ONE_HOT_WIDTH - 1; i >= 0; i--) begin
      if (one_hot_code[i]) begin
        low_idx = BIN_WIDTH'(i);
      end
    end
    is_zero = (one_hot_code == '0);
`ifdef NS_1HOT2BIN_PRIORITY_EN
    enc_bin = low_idx;
    enc_err = is_zero;
`else
    // Clearing the lowest set bit leaves zero only for a single-bit vector.
    is_single = !is_zero && ((one_hot_code & (one_hot_code - c_one)) == '0);
    enc_bin   = is_single ? low_idx : '0;
    enc_err   = !is_single;
`endif
  end

  always_comb begin
    push       = in_valid && in_ready_q;
    pop        = (count_q != 2'd0) && out_ready;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q + {1'b0, push} - {1'b0, pop};
    in_ready_d = (count_d != 2'd2);
    err_cnt_d  = err_cnt_q;

    // A lone popped entry stays in head_q so the outputs hold when empty.
    case (count_q)
      2'd0: if (push) head_d = {enc_bin, enc_err};
      2'd1: begin
        if (push && pop) begin
          head_d = {enc_bin, enc_err};
        end else if (push) begin
          tail_d = {enc_bin, enc_err};
        end
      end
      default: if (pop) head_d = tail_q;
    endcase

    if (err_cnt_clr) begin
      err_cnt_d = '0;
    end else if (push && enc_err && (err_cnt_q != {ERR_CNT_WIDTH{1'b1}})) begin
      err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= 2'd0;
      in_ready_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (count_q != 2'd0);
  assign bin_code  = head_q[ENTRY_W-1:1];
  assign out_err   = head_q[0];
  assign err_cnt   = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ns_1hot2bin_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_ns_1hot2bin_pipe
// Description : Directed self-checking bench for ns_1hot2bin_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ns_1hot2bin_pipe;

  localparam int OHW = 8;
  localparam int BW  = 3;
  localparam int CW  = 2;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [OHW-1:0] one_hot_code;
  logic           out_valid;
  logic           out_ready;
  logic [BW-1:0]  bin_code;
  logic           out_err;
  logic [CW-1:0]  err_cnt;
  logic           err_cnt_clr;

  int n_vec;
  int n_bad;

  ns_1hot2bin_pipe #(
    .ONE_HOT_WIDTH(OHW),
    .ERR_CNT_WIDTH(CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .one_hot_code(one_hot_code),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .bin_code    (bin_code),
    .out_err     (out_err),
    .err_cnt     (err_cnt),
    .err_cnt_clr (err_cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Step one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec        = 0;
    n_bad        = 0;
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    one_hot_code = '0;
    out_ready    = 1'b0;
    err_cnt_clr  = 1'b0;

    // Reset state and release
    step();
    step();
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_bin", 32'(bin_code), 0);
    check("rst_err", 32'(out_err), 0);
    check("rst_err_cnt", 32'(err_cnt), 0);
    rst_n = 1'b1;
    #2;
    check("rel_in_ready_pre", 32'(in_ready), 0);
    step();
    check("rel_in_ready_post", 32'(in_ready), 1);
    check("rel_out_valid", 32'(out_valid), 0);

    // Full-rate legal stream with out_ready held high
    out_ready = 1'b1;
    for (int i = 0; i < OHW; i++) begin
      in_valid     = 1'b1;
      one_hot_code = OHW'(1) << i;
      step();
      check("strm_valid", 32'(out_valid), 1);
      check("strm_bin", 32'(bin_code), 32'(i));
      check("strm_err", 32'(out_err), 0);
      check("strm_in_ready", 32'(in_ready), 1);
    end
    in_valid = 1'b0;
    step();
    check("strm_drain_valid", 32'(out_valid), 0);
    check("strm_hold_bin", 32'(bin_code), 7);

    // Output stall: two beats fill the buffer, third held off
    out_ready    = 1'b0;
    in_valid     = 1'b1;
    one_hot_code = 8'h04;
    step();
    check("stall_b1_valid", 32'(out_valid), 1);
    check("stall_b1_bin", 32'(bin_code), 2);
    check("stall_b1_in_ready", 32'(in_ready), 1);
    one_hot_code = 8'h80;
    step();
    check("stall_full_in_ready", 32'(in_ready), 0);
    check("stall_full_bin", 32'(bin_code), 2);
    one_hot_code = 8'h01;
    step();
    check("stall_held_in_ready", 32'(in_ready), 0);
    check("stall_held_bin", 32'(bin_code), 2);
    check("stall_held_valid", 32'(out_valid), 1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("stall_pop1_bin", 32'(bin_code), 7);
    check("stall_pop1_valid", 32'(out_valid), 1);
    check("stall_pop1_in_ready", 32'(in_ready), 1);
    step();
    check("stall_pop2_valid", 32'(out_valid), 0);
    check("stall_pop2_hold", 32'(bin_code), 7);

    // Illegal codes: zero, then multi-hot 8'h12
    in_valid     = 1'b1;
    one_hot_code = 8'h00;
    step();
    check("zero_bin", 32'(bin_code), 0);
    check("zero_err", 32'(out_err), 1);
    check("zero_err_cnt", 32'(err_cnt), 1);
    one_hot_code = 8'h12;
    step();
    check("multi_valid", 32'(out_valid), 1);
`ifdef NS_1HOT2BIN_PRIORITY_EN
    check("multi_bin", 32'(bin_code), 1);
    check("multi_err", 32'(out_err), 0);
    check("multi_err_cnt", 32'(err_cnt), 1);
`else
    check("multi_bin", 32'(bin_code), 0);
    check("multi_err", 32'(out_err), 1);
    check("multi_err_cnt", 32'(err_cnt), 2);
`endif
    in_valid = 1'b0;
    step();

    // Saturation of the 2-bit counter and clear-over-increment
    err_cnt_clr = 1'b1;
    step();
    err_cnt_clr = 1'b0;
    check("clr_err_cnt", 32'(err_cnt), 0);
    for (int k = 1; k <= 5; k++) begin
      in_valid     = 1'b1;
      one_hot_code = 8'h00;
      step();
      check("sat_err_cnt", 32'(err_cnt), (k > 3) ? 3 : k);
    end
    err_cnt_clr = 1'b1;
    step();
    check("clr_win_err_cnt", 32'(err_cnt), 0);
    check("clr_win_err", 32'(out_err), 1);
    err_cnt_clr = 1'b0;
    in_valid    = 1'b0;
    step();

    // Asynchronous reset with a full buffer
    out_ready    = 1'b0;
    in_valid     = 1'b1;
    one_hot_code = 8'h01;
    step();
    one_hot_code = 8'h00;
    step();
    in_valid = 1'b0;
    check("pre_rst_full", 32'(in_ready), 0);
    check("pre_rst_err_cnt", 32'(err_cnt), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_in_ready", 32'(in_ready), 0);
    check("mid_rst_err_cnt", 32'(err_cnt), 0);
    check("mid_rst_bin", 32'(bin_code), 0);
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("post_rst_no_stale", 32'(out_valid), 0);
    end
    check("post_rst_in_ready", 32'(in_ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
